// File: rtl/wb_bus_pkg.sv
// Shared types and constants for the Wishbone single-master address decoder.
package wb_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } wb_dec_state_t;

    localparam int   IDXW    = 2;
    localparam logic RTY_TIE = 1'b0;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating stall counter; o_tc flags the last cycle a slave may take to ack.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_async_rst_b,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_async_rst_b) begin
        if (!i_async_rst_b) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TC_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/wb_bus_decoder.sv
// Wishbone single-master decoder: strobes one slave per cycle, registers its
// ack/read data back, and terminates unmapped or stalled cycles with err.
module wb_bus_decoder
    import wb_bus_pkg::*;
#(
    parameter int dwidth  = 32,
    parameter int awidth  = 32,
    parameter int NSLV    = 4,
    parameter int SLV_AW  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     async_rst_b,
    input  logic                     cyc,
    input  logic                     stb,
    input  logic                     we,
    input  logic [dwidth/8-1:0]      sel,
    input  logic [awidth-1:0]        adr,
    input  logic [dwidth-1:0]        dout,
    output logic [dwidth-1:0]        din,
    output logic                     ack,
    output logic                     err,
    output logic                     rty,
    output logic [NSLV-1:0]          slv_stb,
    output logic                     slv_cyc,
    output logic                     slv_we,
    output logic [dwidth/8-1:0]      slv_sel,
    output logic [SLV_AW-1:0]        slv_adr,
    output logic [dwidth-1:0]        slv_dat_o,
    input  logic [NSLV-1:0]          slv_ack,
    input  logic [NSLV*dwidth-1:0]   slv_dat_i,
    output logic                     to_flag,
    output logic [IDXW-1:0]          to_idx,
    input  logic                     to_clr
);

    wb_dec_state_t r_state, w_nstate;

    logic [IDXW-1:0]     r_idx;
    logic                r_ack, r_err;
    logic [dwidth-1:0]   r_din;
    logic [NSLV-1:0]     r_slv_stb;
    logic                r_slv_cyc, r_slv_we;
    logic [dwidth/8-1:0] r_slv_sel;
    logic [SLV_AW-1:0]   r_slv_adr;
    logic [dwidth-1:0]   r_slv_dat_o;
    logic                r_to_flag;
    logic [IDXW-1:0]     r_to_idx;

    logic [IDXW-1:0]     w_req_idx, w_err_idx;
    logic                w_mapped, w_sel_ack, w_tc;
    logic [dwidth-1:0]   w_rd_dat;
    logic [NSLV-1:0]     w_stb_oh;
    logic                w_accept, w_drop, w_rd_ld;
    logic                w_ack_nx, w_err_nx, w_to_set;
    logic                w_cnt_clr, w_cnt_en;
    logic                w_unused;

    assign w_req_idx = adr[SLV_AW+1:SLV_AW];
    assign w_mapped  = ({1'b0, w_req_idx} < (IDXW+1)'(NSLV));
    assign w_stb_oh  = NSLV'(1) << w_req_idx;
    assign w_err_idx = (r_state == IDLE) ? w_req_idx : r_idx;
    assign w_unused  = &{1'b0, adr[awidth-1:SLV_AW+2]};

    // Only the latched slave's ack and data are ever looked at.
    always_comb begin
        w_sel_ack = 1'b0;
        w_rd_dat  = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_sel_ack = slv_ack[k];
                w_rd_dat  = slv_dat_i[k*dwidth +: dwidth];
            end
        end
    end

    wb_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_to_cnt (
        .i_clk         (clk),
        .i_async_rst_b (async_rst_b),
        .i_clr         (w_cnt_clr),
        .i_en          (w_cnt_en),
        .o_tc          (w_tc)
    );

    always_ff @(posedge clk or negedge async_rst_b) begin
        if (!async_rst_b) r_state <= IDLE;
        else              r_state <= w_nstate;
    end

    always_comb begin
        w_nstate  = r_state;
        w_accept  = 1'b0;
        w_drop    = 1'b0;
        w_rd_ld   = 1'b0;
        w_ack_nx  = 1'b0;
        w_err_nx  = 1'b0;
        w_to_set  = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cyc && stb) begin
                    if (w_mapped) begin
                        w_accept  = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_nstate  = ACTIVE;
                    end else begin
                        w_err_nx = 1'b1;
                        w_to_set = 1'b1;
                        w_nstate = DONE;
                    end
                end
            end
            ACTIVE: begin
                // ack beats a coinciding timeout
                if (w_sel_ack) begin
                    w_ack_nx = 1'b1;
                    w_rd_ld  = !r_slv_we;
                    w_drop   = 1'b1;
                    w_nstate = DONE;
                end else if (w_tc) begin
                    w_err_nx = 1'b1;
                    w_to_set = 1'b1;
                    w_drop   = 1'b1;
                    w_nstate = DONE;
                end else if (!cyc) begin
                    w_drop   = 1'b1;
                    w_nstate = IDLE;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            DONE:    w_nstate = IDLE;
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_b) begin
        if (!async_rst_b) begin
            r_idx       <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_din       <= '0;
            r_slv_stb   <= '0;
            r_slv_cyc   <= 1'b0;
            r_slv_we    <= 1'b0;
            r_slv_sel   <= '0;
            r_slv_adr   <= '0;
            r_slv_dat_o <= '0;
            r_to_flag   <= 1'b0;
            r_to_idx    <= '0;
        end else begin
            r_ack <= w_ack_nx;
            r_err <= w_err_nx;
            if (w_accept) begin
                r_idx       <= w_req_idx;
                r_slv_stb   <= w_stb_oh;
                r_slv_cyc   <= 1'b1;
                r_slv_we    <= we;
                r_slv_sel   <= sel;
                r_slv_adr   <= adr[SLV_AW-1:0];
                r_slv_dat_o <= dout;
            end else if (w_drop) begin
                r_slv_stb <= '0;
                r_slv_cyc <= 1'b0;
            end
            if (w_rd_ld) r_din <= w_rd_dat;
            if (w_to_set) begin
                r_to_flag <= 1'b1;
                r_to_idx  <= w_err_idx;
            end else if (to_clr) begin
                r_to_flag <= 1'b0;
            end
        end
    end

    assign din       = r_din;
    assign ack       = r_ack;
    assign err       = r_err;
    assign rty       = RTY_TIE;
    assign slv_stb   = r_slv_stb;
    assign slv_cyc   = r_slv_cyc;
    assign slv_we    = r_slv_we;
    assign slv_sel   = r_slv_sel;
    assign slv_adr   = r_slv_adr;
    assign slv_dat_o = r_slv_dat_o;
    assign to_flag   = r_to_flag;
    assign to_idx    = r_to_idx;

endmodule
